// File: rtl/wave_generator_pkg.sv
// rtl/wave_generator_pkg.sv - shared wave select codes, sample width and waveform helpers
// Purpose: constants and pure functions shared by the wave generator and the
//          downstream amplitude-scaling stage.
// Ports:   none (package).
package wave_generator_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic [1:0] WAVE_SAW   = 2'b00;
  localparam logic [1:0] WAVE_SQR   = 2'b01;
  localparam logic [1:0] WAVE_TRI   = 2'b10;
  localparam logic [1:0] WAVE_NOISE = 2'b11;

  localparam logic [SAMPLE_W-1:0] LFSR_SEED = 8'h01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Map the 8-bit phase index (or noise register) to an output sample.
  function automatic logic [SAMPLE_W-1:0] wave_shape(
    input logic [1:0]          sel,
    input logic [SAMPLE_W-1:0] p,
    input logic [SAMPLE_W-1:0] lfsr
  );
    logic [SAMPLE_W-1:0] ramp;
    ramp = {p[SAMPLE_W-2:0], 1'b0};
    case (sel)
      WAVE_SAW: wave_shape = p;
      WAVE_SQR: wave_shape = p[SAMPLE_W-1] ? 8'hFF : 8'h00;
      WAVE_TRI: wave_shape = p[SAMPLE_W-1] ? ~ramp : ramp;
      default:  wave_shape = lfsr;
    endcase
  endfunction

  // Fibonacci taps 8,6,5,4; a non-zero seed never reaches the all-zero state.
  function automatic logic [SAMPLE_W-1:0] lfsr_next(input logic [SAMPLE_W-1:0] lfsr);
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  endfunction

endpackage

// File: rtl/wave_prescaler.sv
// rtl/wave_prescaler.sv - sample-rate prescaler producing a tick every sample_div+1 run cycles
// Purpose: divides the clock down to the sample rate.
// Ports:   clk, rst_n (async active-low), run (count enable), clear (restart,
//          wins over tick), sample_div (terminal count), tick (sample strobe).
module wave_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] sample_div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Equality compare only: if sample_div drops below the count, the counter
  // runs on through its natural wrap before matching again.
  always_comb begin
    tick    = run && !clear && (count_q == sample_div);
    count_d = count_q + {{(DIV_W-1){1'b0}}, 1'b1};
    if (clear || !run || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - phase-accumulator waveform source (saw/square/triangle/noise)
// Purpose: produces registered 8-bit samples at a prescaled rate for the
//          amplitude-scaling stage.
// Ports:   clk, rst_n (async active-low), enable (run/hold), sync (restart
//          pulse), waveSel (shape), freqStep (phase increment), sampleDiv
//          (prescaler terminal count), sampleOut (sample), sampleValid
//          (new-sample strobe), cycleWrap (phase carry-out strobe).
module wave_generator
  import wave_generator_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                sync,
  input  logic [1:0]          waveSel,
  input  logic [PHASE_W-1:0]  freqStep,
  input  logic [DIV_W-1:0]    sampleDiv,
  output logic [SAMPLE_W-1:0] sampleOut,
  output logic                sampleValid,
  output logic                cycleWrap
);

  run_state_e          state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [SAMPLE_W-1:0] lfsr_q, lfsr_d;
  logic [1:0]          active_sel_q, active_sel_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;

  logic                run;
  logic                tick;
  logic [PHASE_W:0]    phase_sum;
  logic                wrap;
  logic [SAMPLE_W-1:0] p;

  // The first enabled cycle already behaves as RUN so that sampleDiv=0 ticks
  // immediately; the cycle enable falls behaves as IDLE (no tick).
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          run     = 1'b1;
        end
      end
      default: begin
        run = enable;
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  wave_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clear      (sync),
    .sample_div (sampleDiv),
    .tick       (tick)
  );

  assign phase_sum = {1'b0, phase_q} + {1'b0, freqStep};
  assign wrap      = phase_sum[PHASE_W];
  assign p         = phase_q[PHASE_W-1 -: SAMPLE_W];

  always_comb begin
    phase_d      = phase_q;
    lfsr_d       = lfsr_q;
    active_sel_d = active_sel_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    wrap_d       = 1'b0;
    if (sync) begin
      phase_d      = '0;
      lfsr_d       = LFSR_SEED;
      active_sel_d = waveSel;
    end else if (!run) begin
      active_sel_d = waveSel;
    end else if (tick) begin
      phase_d  = phase_sum[PHASE_W-1:0];
      sample_d = wave_shape(active_sel_q, p, lfsr_q);
      valid_d  = 1'b1;
      wrap_d   = wrap;
      if (active_sel_q == WAVE_NOISE) begin
        lfsr_d = lfsr_next(lfsr_q);
      end
      // Shape changes only at a period boundary so no partial cycle is emitted.
      if (wrap) begin
        active_sel_d = waveSel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      active_sel_q <= WAVE_SAW;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lfsr_q       <= lfsr_d;
      active_sel_q <= active_sel_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign sampleOut   = sample_q;
  assign sampleValid = valid_q;
  assign cycleWrap   = wrap_q;

endmodule

// File: tb/tb_wave_generator.sv
// tb/tb_wave_generator.sv - scoreboard bench for wave_generator
module tb_wave_generator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sync;
  logic [1:0]  waveSel;
  logic [15:0] freqStep;
  logic [7:0]  sampleDiv;
  logic [7:0]  sampleOut;
  logic        sampleValid;
  logic        cycleWrap;

  wave_generator #(.PHASE_W(16), .DIV_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sync        (sync),
    .waveSel     (waveSel),
    .freqStep    (freqStep),
    .sampleDiv   (sampleDiv),
    .sampleOut   (sampleOut),
    .sampleValid (sampleValid),
    .cycleWrap   (cycleWrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] exp_q[$];   // {wrap, sample}
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_gap = 0;
  int run_id = 0;
  int mon_run = -1;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per presented sample, checks strobe spacing.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && sampleValid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_sample got out=%02h wrap=%0b required none", sampleOut, cycleWrap);
      end else begin
        e = exp_q.pop_front();
        if ({cycleWrap, sampleOut} !== e) begin
          miscompares++;
          $display("FAIL sample got out=%02h wrap=%0b required out=%02h wrap=%0b",
                   sampleOut, cycleWrap, e[7:0], e[8]);
        end
      end
      if (exp_gap != 0 && mon_run == run_id) begin
        vectors++;
        if (cyc - last_cyc != exp_gap) begin
          miscompares++;
          $display("FAIL strobe_gap got %0d required %0d", cyc - last_cyc, exp_gap);
        end
      end
      mon_run  = run_id;
      last_cyc = cyc;
    end
  end

  task automatic push(input logic [7:0] s, input logic w);
    exp_q.push_back({w, s});
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Load a configuration while idle and restart phase/noise with a sync pulse.
  task automatic configure(input logic [1:0] sel, input logic [15:0] fs,
                           input logic [7:0] div, input int gap);
    enable    = 1'b0;
    waveSel   = sel;
    freqStep  = fs;
    sampleDiv = div;
    exp_gap   = gap;
    sync      = 1'b1;
    step();
    sync      = 1'b0;
    step();
  endtask

  task automatic wait_empty(input int max_cycles, input bit drop);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    if (drop) enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sync = 1'b0;
    waveSel = 2'b00; freqStep = 16'h0100; sampleDiv = 8'd0;
    step();
    chk("reset_out",   {8'h0, sampleOut},   16'h0);
    chk("reset_valid", {15'h0, sampleValid}, 16'h0);
    chk("reset_wrap",  {15'h0, cycleWrap},   16'h0);
    step();
    rst_n = 1'b1;
    step();

    // Sawtooth, one sample per cycle, full period plus one.
    exp_gap = 1;
    for (int i = 0; i < 257; i++) push(8'(i), i == 255);
    run_id++;
    enable = 1'b1;
    step();
    chk("first_valid_latency", {15'h0, sampleValid}, 16'h1);
    wait_empty(400, 1'b1);

    // Square, tick every 4 cycles.
    configure(2'b01, 16'h4000, 8'd3, 4);
    for (int i = 0; i < 8; i++) push((i % 4) >= 2 ? 8'hFF : 8'h00, (i % 4) == 3);
    run_id++;
    enable = 1'b1;
    wait_empty(60, 1'b1);

    // Triangle.
    configure(2'b10, 16'h4000, 8'd0, 1);
    begin
      logic [7:0] tri_tab [4];
      tri_tab = '{8'h00, 8'h80, 8'hFF, 8'h7F};
      for (int i = 0; i < 8; i++) push(tri_tab[i % 4], (i % 4) == 3);
    end
    run_id++;
    enable = 1'b1;
    wait_empty(40, 1'b1);

    // Noise with frozen phase, then a sync restart while running.
    configure(2'b11, 16'h0000, 8'd0, 1);
    push(8'h01, 0); push(8'h02, 0); push(8'h04, 0); push(8'h08, 0); push(8'h11, 0);
    run_id++;
    enable = 1'b1;
    wait_empty(40, 1'b0);
    push(8'h01, 0); push(8'h02, 0); push(8'h04, 0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_no_strobe", {15'h0, sampleValid}, 16'h0);
    chk("sync_out_hold",  {8'h0, sampleOut},    16'h0011);
    run_id++;
    wait_empty(40, 1'b1);

    // Deferred select: saw continues to the wrap, then square begins.
    configure(2'b00, 16'h1000, 8'd0, 1);
    for (int i = 0; i < 16; i++) push(8'(i * 16), i == 15);
    for (int i = 0; i < 9; i++) push(i >= 8 ? 8'hFF : 8'h00, 1'b0);
    run_id++;
    enable = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_q.size() > 21 && n < 40) begin
        step();
        n++;
      end
      chk("defer_reached_p30", 16'(exp_q.size() <= 21), 16'h1);
    end
    waveSel = 2'b01;
    wait_empty(60, 1'b1);

    // Hold: stop after p=40, sampleOut holds, resume at p=50.
    configure(2'b00, 16'h1000, 8'd0, 1);
    for (int i = 0; i < 5; i++) push(8'(i * 16), 1'b0);
    run_id++;
    enable = 1'b1;
    wait_empty(40, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", {15'h0, sampleValid}, 16'h0);
      chk("hold_out",   {8'h0, sampleOut},    16'h0040);
    end
    push(8'h50, 0); push(8'h60, 0); push(8'h70, 0);
    run_id++;
    enable = 1'b1;
    wait_empty(40, 1'b0);

    // Asynchronous reset mid-run.
    chk("pre_reset_valid", {15'h0, sampleValid}, 16'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out",   {8'h0, sampleOut},    16'h0);
    chk("async_reset_valid", {15'h0, sampleValid}, 16'h0);
    chk("async_reset_wrap",  {15'h0, cycleWrap},   16'h0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", {15'h0, sampleValid}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
